// File: rtl/cpu_core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core_seq_pkg
// Description : Shared types and helpers for the jacaranda program-sequencing
//               unit: return-stack entry layout, "no interrupt" sentinel and
//               the lowest-index-first priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_core_seq_pkg;

    // Default configuration of the sequencer.
    localparam int SEQ_PC_W  = 8;
    localparam int SEQ_N_IRQ = 4;
    localparam int SEQ_ID_W  = $clog2(SEQ_N_IRQ + 1);

    // Priority level meaning "no interrupt running". It is one past the
    // lowest-priority source id, so every real source compares as higher.
    localparam int IRQ_NONE = SEQ_N_IRQ;

    // One return-stack entry for the default configuration. The top level
    // builds the same layout at its own parameterised widths.
    typedef struct packed {
        logic [SEQ_PC_W-1:0] addr;
        logic                flag;
        logic [SEQ_ID_W-1:0] id;
    } stack_entry_t;

    // Index of the lowest set bit among the first n bits of req, or n when
    // none is set. Sources beyond 32 are not supported.
    function automatic int prio_enc(input logic [31:0] req, input int n);
        int r;
        r = n;
        for (int i = 31; i >= 0; i--) begin
            if ((i < n) && req[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_core_seq_irq_stack.sv
`default_nettype none
// ============================================================================
// Module      : irq_stack
// Description : Parameterised LIFO holding interrupt return context. Push and
//               pop are never requested together by the sequencer. Contents
//               are not reset; only the depth pointer is.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_stack
    import cpu_core_seq_pkg::*;
#(
    parameter type T     = stack_entry_t,
    parameter int  DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  T                             din,
    output T                             top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              r_mem [DEPTH];
    logic [DW-1:0] r_depth;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;

    // The write slot is the current depth; the top entry sits one below.
    assign w_wr_idx  = IW'(r_depth);
    assign w_top_idx = IW'(r_depth - DW'(1));

    assign full  = (r_depth == DW'(DEPTH));
    assign empty = (r_depth == '0);
    assign top   = r_mem[w_top_idx];
    assign depth = r_depth;

    // Depth pointer: grows on push, shrinks on pop, saturating at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else if (push && !full) begin
            r_depth <= r_depth + DW'(1);
        end else if (pop && !empty) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    // Entry storage: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_core_seq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_core_seq
// Description : Program counter, branch flag and vectored, prioritised
//               interrupt controller with hardware return stack.
//               Build option CPU_CORE_SEQ_NEST_EN: when defined, interrupts
//               nest up to STACK_DEPTH levels; when undefined, a single level
//               is kept and no interrupt is taken while in_isr is high.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_core_seq
    import cpu_core_seq_pkg::*;
#(
    parameter int PC_W        = SEQ_PC_W,
    parameter int N_IRQ       = SEQ_N_IRQ,
    parameter int STACK_DEPTH = 4
)(
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               jmp_en,
    input  logic                               je_en,
    input  logic                               ret,
    input  logic                               flag_w_en,
    input  logic                               alu_flag,
    input  logic [PC_W-1:0]                    target,
    input  logic [N_IRQ-1:0]                   irq_req,
    input  logic [N_IRQ-1:0]                   irq_en,
    input  logic [N_IRQ*PC_W-1:0]              irq_vec,
    output logic [PC_W-1:0]                    pc,
    output logic                               flag,
    output logic                               in_isr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   isr_depth,
    output logic [N_IRQ-1:0]                   irq_ack,
    output logic                               stack_err
);

    localparam int ID_W    = $clog2(N_IRQ + 1);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
`ifdef CPU_CORE_SEQ_NEST_EN
    localparam int EFF_DEPTH = STACK_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam int              EFF_DW  = $clog2(EFF_DEPTH + 1);
    localparam logic [ID_W-1:0] ID_NONE = ID_W'(N_IRQ);

    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic            flag;
        logic [ID_W-1:0] id;
    } entry_t;

    logic [PC_W-1:0]   r_pc;
    logic              r_flag;
    logic [N_IRQ-1:0]  r_ack;
    logic              r_err;

    entry_t            w_push_entry;
    entry_t            w_top;
    logic              w_full;
    logic              w_empty;
    logic [EFF_DW-1:0] w_depth;
    logic              w_pop;
    logic              w_take;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_npc;
    logic              w_nflag;
    logic [PC_W-1:0]   w_vec;
    logic [ID_W-1:0]   w_cand;
    logic [ID_W-1:0]   w_cur;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pop    = ret && !w_empty;
    assign w_cand   = ID_W'(prio_enc(32'(irq_req & irq_en), N_IRQ));
    assign w_cur    = w_empty ? ID_NONE : w_top.id;

    // An interrupt preempts only a strictly lower running level; a return
    // in the same cycle wins and the request is re-judged next cycle. With
    // a single-entry stack "full" is the same as "in an ISR".
    assign w_take = (w_cand != ID_NONE) && (w_cand < w_cur) && !w_full && !ret;

    assign w_push_entry = '{addr: w_npc, flag: w_nflag, id: w_cand};

    // Retiring instruction's next PC and flag; a return with an empty
    // stack behaves as a plain fall-through.
    always_comb begin
        w_npc   = w_pc_inc;
        w_nflag = r_flag;
        if (ret) begin
            if (!w_empty) begin
                w_npc   = w_top.addr;
                w_nflag = w_top.flag;
            end
        end else begin
            if (jmp_en || (je_en && r_flag)) begin
                w_npc = target;
            end
            if (je_en) begin
                w_nflag = 1'b0;
            end else if (flag_w_en) begin
                w_nflag = alu_flag;
            end
        end
    end

    // Handler address of the winning candidate.
    always_comb begin
        w_vec = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_cand == ID_W'(i)) begin
                w_vec = irq_vec[i*PC_W +: PC_W];
            end
        end
    end

    // Architectural state: PC, flag, acknowledge pulse and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc   <= '0;
            r_flag <= 1'b0;
            r_ack  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pc   <= w_take ? w_vec : w_npc;
            r_flag <= w_nflag;
            r_ack  <= w_take ? (N_IRQ'(1) << w_cand) : '0;
            if (ret && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    irq_stack #(
        .T     (entry_t),
        .DEPTH (EFF_DEPTH)
    ) u_stack (
        .clk   (clock),
        .rst   (reset),
        .push  (w_take),
        .pop   (w_pop),
        .din   (w_push_entry),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty),
        .depth (w_depth)
    );

    assign pc        = r_pc;
    assign flag      = r_flag;
    assign irq_ack   = r_ack;
    assign stack_err = r_err;
    assign in_isr    = !w_empty;
    assign isr_depth = DEPTH_W'(w_depth);

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_core_seq
// Description : Self-checking bench for cpu_core_seq: directed vector table,
//               counting sweep, and randomized traffic against a queue-based
//               reference model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core_seq;

    localparam int PC_W        = 8;
    localparam int N_IRQ       = 4;
    localparam int STACK_DEPTH = 2;
`ifdef CPU_CORE_SEQ_NEST_EN
    localparam int EFF_DEPTH = STACK_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jmp_en = 1'b0, je_en = 1'b0, ret = 1'b0;
    logic        flag_w_en = 1'b0, alu_flag = 1'b0;
    logic [7:0]  target = '0;
    logic [3:0]  irq_req = '0;
    logic [3:0]  irq_en = 4'hF;
    logic [31:0] irq_vec = 32'h3080_A0C0;
    logic [7:0]  pc;
    logic        flag, in_isr;
    logic [1:0]  isr_depth;
    logic [3:0]  irq_ack;
    logic        stack_err;

    cpu_core_seq #(
        .PC_W        (PC_W),
        .N_IRQ       (N_IRQ),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .jmp_en    (jmp_en),
        .je_en     (je_en),
        .ret       (ret),
        .flag_w_en (flag_w_en),
        .alu_flag  (alu_flag),
        .target    (target),
        .irq_req   (irq_req),
        .irq_en    (irq_en),
        .irq_vec   (irq_vec),
        .pc        (pc),
        .flag      (flag),
        .in_isr    (in_isr),
        .isr_depth (isr_depth),
        .irq_ack   (irq_ack),
        .stack_err (stack_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] addr;
        logic       flag;
        int         id;
    } ent_t;

    ent_t       m_stk[$];
    logic [7:0] m_pc   = '0;
    logic       m_flag = 1'b0;
    logic [3:0] m_ack  = '0;
    logic       m_err  = 1'b0;

    task automatic model_step();
        logic [7:0] npc;
        logic       nflag;
        int         cur, cand;
        ent_t       e;
        if (reset) begin
            m_pc = '0; m_flag = 1'b0; m_ack = '0; m_err = 1'b0;
            m_stk.delete();
        end else begin
            if (ret) begin
                if (m_stk.size() > 0) begin
                    e = m_stk.pop_back();
                    npc = e.addr; nflag = e.flag;
                end else begin
                    npc = m_pc + 8'd1; nflag = m_flag; m_err = 1'b1;
                end
            end else begin
                npc   = (jmp_en || (je_en && m_flag)) ? target : m_pc + 8'd1;
                nflag = je_en ? 1'b0 : (flag_w_en ? alu_flag : m_flag);
            end
            cur  = (m_stk.size() > 0) ? m_stk[m_stk.size()-1].id : N_IRQ;
            cand = N_IRQ;
            for (int i = N_IRQ - 1; i >= 0; i--)
                if (irq_req[i] && irq_en[i]) cand = i;
            m_ack = '0;
            if (!ret && cand < cur && m_stk.size() < EFF_DEPTH) begin
                e.addr = npc; e.flag = nflag; e.id = cand;
                m_stk.push_back(e);
                m_pc = irq_vec[cand*8 +: 8];
                m_ack[cand] = 1'b1;
            end else begin
                m_pc = npc;
            end
            m_flag = nflag;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, all outputs compared after it.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("mdl_pc",    32'(pc),        32'(m_pc));
        check("mdl_flag",  32'(flag),      32'(m_flag));
        check("mdl_ack",   32'(irq_ack),   32'(m_ack));
        check("mdl_depth", 32'(isr_depth), 32'(m_stk.size()));
        check("mdl_inisr", 32'(in_isr),    32'(m_stk.size() != 0));
        check("mdl_err",   32'(stack_err), 32'(m_err));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       jmp, je, rt, fw, alu;
        logic [7:0] tgt;
        logic [3:0] req;
        logic [7:0] e_pc;
        logic       e_flag;
        logic [3:0] e_ack;
        logic [1:0] e_depth;
        logic       e_err;
    } vec_t;

    vec_t rows[$];

    initial begin
        // Interrupt entry with flag write, je inside the ISR, return.
        rows.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h10, 4'b0000, 8'h10, 1'b0, 4'b0000, 2'd0, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 8'h00, 4'b0010, 8'hA0, 1'b1, 4'b0010, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 8'hA5, 4'b0000, 8'hA5, 1'b0, 4'b0000, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 8'h11, 1'b1, 4'b0000, 2'd0, 1'b0});
        // Jump retiring in the entry cycle; return lands on the jump target.
        rows.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h40, 4'b0100, 8'h80, 1'b1, 4'b0100, 2'd1, 1'b0});
`ifdef CPU_CORE_SEQ_NEST_EN
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b1000, 8'h81, 1'b1, 4'b0000, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0001, 8'hC0, 1'b1, 4'b0001, 2'd2, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0010, 8'hC1, 1'b1, 4'b0000, 2'd2, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0010, 8'h82, 1'b1, 4'b0000, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0010, 8'hA0, 1'b1, 4'b0010, 2'd2, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 8'h83, 1'b1, 4'b0000, 2'd1, 1'b0});
        // ret and id 0 together: ret wins, id 0 enters a cycle later.
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0001, 8'h40, 1'b1, 4'b0000, 2'd0, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0001, 8'hC0, 1'b1, 4'b0001, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 8'h41, 1'b1, 4'b0000, 2'd0, 1'b0});
`else
        // Single level: id 0 waits until the id-2 handler returns.
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0001, 8'h81, 1'b1, 4'b0000, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0001, 8'h82, 1'b1, 4'b0000, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0001, 8'h40, 1'b1, 4'b0000, 2'd0, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0001, 8'hC0, 1'b1, 4'b0001, 2'd1, 1'b0});
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 8'h41, 1'b1, 4'b0000, 2'd0, 1'b0});
`endif
        // Return with an empty stack: fall through, sticky error.
        rows.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00, 4'b0000, 8'h42, 1'b1, 4'b0000, 2'd0, 1'b1});
        rows.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 4'b0000, 8'h43, 1'b1, 4'b0000, 2'd0, 1'b1});
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    32'(pc),        32'h0);
        check({tag, "_flag"},  32'(flag),      32'h0);
        check({tag, "_inisr"}, 32'(in_isr),    32'h0);
        check({tag, "_depth"}, 32'(isr_depth), 32'h0);
        check({tag, "_ack"},   32'(irq_ack),   32'h0);
        check({tag, "_err"},   32'(stack_err), 32'h0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #2;
        reset = 1'b1;
        cycle();
        cycle();
        check_reset_state("rst0");
        reset = 1'b0;

        // Idle sweep: pc counts through every address and wraps to zero.
        for (int k = 1; k <= 256; k++) begin
            cycle();
            check("seq_pc",   32'(pc),   32'(k % 256));
            check("seq_flag", 32'(flag), 32'h0);
        end

        // Directed table.
        for (int i = 0; i < rows.size(); i++) begin
            jmp_en = rows[i].jmp; je_en = rows[i].je; ret = rows[i].rt;
            flag_w_en = rows[i].fw; alu_flag = rows[i].alu;
            target = rows[i].tgt; irq_req = rows[i].req;
            cycle();
            check($sformatf("dir%0d_pc", i),    32'(pc),        32'(rows[i].e_pc));
            check($sformatf("dir%0d_flag", i),  32'(flag),      32'(rows[i].e_flag));
            check($sformatf("dir%0d_ack", i),   32'(irq_ack),   32'(rows[i].e_ack));
            check($sformatf("dir%0d_depth", i), 32'(isr_depth), 32'(rows[i].e_depth));
            check($sformatf("dir%0d_inisr", i), 32'(in_isr),    32'(rows[i].e_depth != 2'd0));
            check($sformatf("dir%0d_err", i),   32'(stack_err), 32'(rows[i].e_err));
        end
        jmp_en = 0; je_en = 0; ret = 0; flag_w_en = 0; alu_flag = 0; irq_req = '0;

        // Reset clears the sticky error and any stack state.
        reset = 1'b1;
        cycle();
        check_reset_state("rst1");
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            jmp_en    = ($urandom_range(0, 7) == 0);
            je_en     = ($urandom_range(0, 5) == 0);
            ret       = ($urandom_range(0, 5) == 0);
            flag_w_en = ($urandom_range(0, 3) == 0);
            alu_flag  = 1'($urandom);
            target    = 8'($urandom);
            for (int b = 0; b < N_IRQ; b++)
                irq_req[b] = ($urandom_range(0, 4) == 0);
            irq_en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_core_seq.md
# cpu_core_seq

Parametrised program-sequencing unit for the next-generation jacaranda core: program counter, branch flag, and a vectored, prioritised, nestable interrupt controller with a hardware return stack. It replaces the single-source, single-level PC/flag/interrupt logic. It consumes decoded control strobes from the main controller and the ALU flag bit. It drives the instruction-fetch address and the register-bank select.

## Interface
- `PC_W`, 8: program counter and jump-target width.
- `N_IRQ`, 4: number of interrupt sources. Index 0 is the highest priority.
- `STACK_DEPTH`, 4: maximum interrupt nesting depth, ≥1.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `jmp_en`  in  1  unconditional jump to `target`.
- `je_en`  in  1  jump to `target` if `flag`; clears `flag`.
- `ret`  in  1  return from interrupt.
- `flag_w_en`  in  1  load `flag` from `alu_flag`.
- `alu_flag`  in  1  ALU result bit 0.
- `target`  in  PC_W  jump target (rs data).
- `irq_req`  in  N_IRQ  level-sensitive requests.
- `irq_en`  in  N_IRQ  per-source enable mask.
- `irq_vec`  in  N_IRQ*PC_W  flattened handler addresses; source i occupies bits [i*PC_W +: PC_W].
- `pc`  out  PC_W  fetch address.
- `flag`  out  1  branch flag.
- `in_isr`  out  1  high when stack depth ≠ 0; selects the interrupt register bank.
- `isr_depth`  out  $clog2(STACK_DEPTH+1)  current nesting depth.
- `irq_ack`  out  N_IRQ  one-hot, one-cycle acknowledge.
- `stack_err`  out  1  sticky flag: ret with an empty stack.

## Operation
- Sequential next PC (`npc`), in priority order:
  - `ret`: the popped address.
  - `jmp_en`: `target`.
  - `je_en` && `flag`: `target`.
  - Otherwise `pc+1`, wrapping modulo 2^PC_W.
- Flag next value (`nflag`), in priority order:
  - `ret`: the popped flag.
  - `je_en`: 0.
  - `flag_w_en`: `alu_flag`.
  - Otherwise hold.
- Current priority `cur`:
  - Source id of the top stack entry.
  - N_IRQ ("none") when the stack is empty.
- Candidate: the lowest index i with `irq_req[i] && irq_en[i]`.
- Take the interrupt when all of the following hold:
  - A candidate exists.
  - i < `cur` (strictly higher priority than the running level).
  - Stack not full.
  - `ret` is low.
- Entry, in the same edge:
  - Push {`npc`, `nflag`, i}.
  - `pc` ← `irq_vec[i]`.
  - `flag` ← `nflag`.
  - `irq_ack[i]` ← 1.
- The current instruction always retires. Its jump or flag effect is captured in the pushed entry.
- `ret` with a non-empty stack: pop, then restore `pc` and `flag`. `cur` reverts to the next entry.
- `ret` with an empty stack:
  - Treated as a non-branch: `pc+1`, flag held.
  - `stack_err` ← 1.
- Equal- or lower-priority requests, and requests arriving while the stack is full, are deferred, not dropped. Requests are level-sensitive; the device holds them until serviced.
- A request still high in the `irq_ack` cycle does not re-enter, because i == `cur`. The device clears it on ack.
- `ret` and a qualifying request in the same cycle: `ret` wins. The request is re-evaluated next cycle against the restored `cur`.
- Disabling `irq_en[i]` never affects an already-entered level.

## Timing
- Every output is a register, updated on each rising edge. There is no stall.
- Interrupt latency: request sampled at edge N, `pc` == vector after edge N.
- `irq_ack` is high exactly in the first cycle in which `pc` == vector.
- Reset values:
  - `pc`=0, `flag`=0, `in_isr`=0, `isr_depth`=0.
  - `irq_ack`=0, `stack_err`=0.
  - Stack contents are don't-care; the depth pointer is 0.
- Reset mid-ISR discards all stack state. `stack_err` clears only on reset.

## Configuration
- `CPU_CORE_SEQ_NEST_EN` defined: nesting as specified, up to STACK_DEPTH levels.
- `CPU_CORE_SEQ_NEST_EN` undefined:
  - Effective depth is 1, and no interrupt is accepted while `in_isr`.
  - Storage beyond one entry is not generated.
  - `isr_depth` is 0 or 1.

## Structure
- Package `cpu_core_seq_pkg`:
  - Stack-entry struct {addr, flag, id}.
  - `IRQ_NONE` constant.
  - Lowest-index-first priority-encode function.
- Sub-module `irq_stack`: a parametrised LIFO with push, pop, full, empty, top and depth. Push and pop are never simultaneous. Everything else stays flat.

## Test plan
(All scenarios use PC_W=8, N_IRQ=4, STACK_DEPTH=2, `irq_vec`={0x30,0x80,0xA0,0xC0} for ids 3..0.)
1. Reset, then 257 idle cycles → `pc` runs 0x00..0xFF, then 0x00; `flag`=0 throughout.
2. At `pc`=0x10, assert `irq_req[1]` with `flag_w_en`, `alu_flag`=1 → `pc`=0xA0, `irq_ack`=0010, `in_isr`=1, `flag`=1. In the ISR, `je_en` clears the flag. Then `ret` → `pc`=0x11, `flag`=1, `in_isr`=0.
3. `jmp_en`, `target`=0x40, in the same cycle as `irq_req[2]` → `pc`=0x80. Then `ret` → `pc`=0x40.
4. Inside the id-2 ISR: assert id 3 → ignored. Assert id 0 → nested, `pc`=0xC0, `isr_depth`=2. A further id-1 request while full → deferred. `ret` → back in id 2; id 1 enters the next cycle.
5. `ret` and `irq_req[0]` in the same cycle at depth 1 → `pc`=return address, then `pc`=0xC0 one cycle later.
6. `ret` at depth 0 → `pc`+1, `stack_err`=1, which stays set until reset. With the macro undefined: an id-0 request during the id-2 ISR → deferred until `ret`.
